// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings for the master BFM: burst types, response codes,
// FSM state type and the AxSIZE encoding helper.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5
    } state_e;

    // AxSIZE is log2 of the beat width in bytes; the bus is always full width.
    function automatic logic [2:0] size_enc(input int bytes);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi4_master_bfm.sv
// Single-outstanding AXI4 master: turns local write/read commands into INCR
// bursts and streams read beats / write responses back on local strobes.
module axi4_master_bfm
    import axi4_pkg::*;
#(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BYTES    = 1,
    parameter int NUM_ID_BITS   = 4,
    parameter int NUM_USER_BITS = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_BYTES*8-1:0]   cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [NUM_ID_BITS-1:0]    cmd_id,
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_BYTES*8-1:0]   wd_data,
    input  logic [DATA_BYTES-1:0]     wd_strb,
    output logic                      rd_valid,
    output logic [DATA_BYTES*8-1:0]   rd_data,
    output logic                      rd_last,
    output logic [1:0]                rd_resp,
    output logic                      wr_done,
    output logic [1:0]                wr_resp,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_BYTES*8-1:0]   awaddr,
    output logic [2:0]                awsize,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awlock,
    output logic [3:0]                awregion,
    output logic [1:0]                awburst,
    output logic [NUM_ID_BITS-1:0]    awid,
    output logic [7:0]                awlen,
    output logic [3:0]                awqos,
    output logic [NUM_USER_BITS-1:0]  awuser,
    output logic                      wvalid,
    input  logic                      wready,
    output logic                      wlast,
    output logic [DATA_BYTES*8-1:0]   wdata,
    output logic [DATA_BYTES-1:0]     wstrb,
    output logic [NUM_USER_BITS-1:0]  wuser,
    input  logic                      bwvalid,
    output logic                      bwready,
    input  logic [1:0]                bresp,
    input  logic [NUM_ID_BITS-1:0]    bid,
    input  logic [NUM_USER_BITS-1:0]  buser,
    output logic                      arvalid,
    input  logic                      aready,
    output logic [ADDR_BYTES*8-1:0]   araddr,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arlock,
    output logic [3:0]                arregion,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [NUM_ID_BITS-1:0]    arid,
    output logic [7:0]                arlen,
    output logic [3:0]                arqos,
    output logic [NUM_USER_BITS-1:0]  aruser,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic                      rlast,
    input  logic [DATA_BYTES*8-1:0]   rdata,
    input  logic [1:0]                rresp,
    input  logic [NUM_ID_BITS-1:0]    rid,
    input  logic [NUM_USER_BITS-1:0]  ruser
);

    localparam logic [2:0] SIZE = size_enc(DATA_BYTES);

    state_e                    state, state_nx;
    logic [ADDR_BYTES*8-1:0]   addr_q;
    logic [7:0]                len_q;
    logic [NUM_ID_BITS-1:0]    id_q;
    logic [7:0]                beat_cnt;
    logic                      beat_last;
    logic                      w_fire;

    assign beat_last = (beat_cnt == len_q);
    assign w_fire    = (state == WR_DATA) && wd_valid && wready;

    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awid     = id_q;
    assign awsize   = SIZE;
    assign awburst  = BURST_INCR;
    assign awcache  = '0;
    assign awprot   = '0;
    assign awlock   = 1'b0;
    assign awregion = '0;
    assign awqos    = '0;
    assign awuser   = '0;
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arid     = id_q;
    assign arsize   = SIZE;
    assign arburst  = BURST_INCR;
    assign arcache  = '0;
    assign arprot   = '0;
    assign arlock   = 1'b0;
    assign arregion = '0;
    assign arqos    = '0;
    assign aruser   = '0;
    assign wuser    = '0;
    assign wdata    = wd_data;
    assign wstrb    = wd_strb;
    assign rd_data  = rdata;
    assign rd_resp  = rresp;
    assign wr_resp  = bresp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                id_q     <= cmd_id;
                beat_cnt <= '0;
            end else if (w_fire) begin
                beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
            end
        end
    end

    // cmd_ready is held low while reset is asserted even though state is IDLE.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        arvalid   = 1'b0;
        wvalid    = 1'b0;
        wd_ready  = 1'b0;
        wlast     = 1'b0;
        bwready   = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = aresetn;
                if (cmd_valid) state_nx = cmd_we ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) state_nx = WR_DATA;
            end
            WR_DATA: begin
                wvalid   = wd_valid;
                wd_ready = wready;
                wlast    = beat_last;
                if (w_fire && beat_last) state_nx = WR_RESP;
            end
            WR_RESP: begin
                bwready = 1'b1;
                wr_done = bwvalid;
                if (bwvalid) state_nx = IDLE;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (aready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                rready   = 1'b1;
                rd_valid = rvalid;
                rd_last  = rvalid && rlast;
                if (rvalid && rlast) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_master_bfm.sv
// Directed bench for axi4_master_bfm: acts as the AXI slave and the local
// command/data source, with hand-computed expectations at each step.
module tb_axi4_master_bfm;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [7:0]  cmd_addr, cmd_len;
    logic [3:0]  cmd_id;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_last, wr_done;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp, wr_resp;
    logic        awvalid, awready, awlock;
    logic [7:0]  awaddr, awlen;
    logic [2:0]  awsize, awprot;
    logic [3:0]  awcache, awregion, awid, awqos, awuser;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb, wuser;
    logic        bwvalid, bwready;
    logic [1:0]  bresp;
    logic [3:0]  bid, buser;
    logic        arvalid, aready, arlock;
    logic [7:0]  araddr, arlen;
    logic [3:0]  arcache, arregion, arid, arqos, aruser;
    logic [2:0]  arprot, arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid, ruser;

    int total = 0;
    int bad   = 0;
    int hs;

    always #5 aclk = ~aclk;

    axi4_master_bfm dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_resp(rd_resp),
        .wr_done(wr_done), .wr_resp(wr_resp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .awcache(awcache), .awprot(awprot), .awlock(awlock), .awregion(awregion),
        .awburst(awburst), .awid(awid), .awlen(awlen), .awqos(awqos), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .wuser(wuser),
        .bwvalid(bwvalid), .bwready(bwready), .bresp(bresp), .bid(bid), .buser(buser),
        .arvalid(arvalid), .aready(aready), .araddr(araddr), .arcache(arcache),
        .arprot(arprot), .arlock(arlock), .arregion(arregion), .arsize(arsize),
        .arburst(arburst), .arid(arid), .arlen(arlen), .arqos(arqos), .aruser(aruser),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rresp(rresp),
        .rid(rid), .ruser(ruser)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // All stimulus changes and checks happen at the falling edge.
    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] addr,
                                 input logic [7:0] len, input logic [3:0] id);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        #1;
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic addrPhase(input logic we, input int delay, input logic [7:0] addr,
                             input logic [7:0] len, input logic [3:0] id);
        for (int k = 0; k <= delay; k++) begin
            if (we) awready = (k == delay);
            else    aready  = (k == delay);
            #1;
            if (we) begin
                checkOutput("awvalid", awvalid, 1);
                checkOutput("awaddr", awaddr, addr);
                checkOutput("awlen", awlen, len);
                checkOutput("awid", awid, id);
            end else begin
                checkOutput("arvalid", arvalid, 1);
                checkOutput("araddr", araddr, addr);
                checkOutput("arlen", arlen, len);
                checkOutput("arid", arid, id);
            end
            checkOutput("cmd_ready_busy", cmd_ready, 0);
            step();
        end
        awready = 1'b0;
        aready  = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; awready = 0; wready = 0;
        bwvalid = 0; bresp = 0; bid = 0; buser = 0; aready = 0;
        rvalid = 0; rlast = 0; rdata = 0; rresp = 0; rid = 0; ruser = 0;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_valids", {awvalid, arvalid, wvalid, bwready, rready}, 0);
        checkOutput("rst_strobes", {rd_valid, wr_done}, 0);
        checkOutput("rst_regs", {awaddr, awlen, awid}, 0);
        checkOutput("const_size", {awsize, arsize}, {3'd2, 3'd2});
        checkOutput("const_burst", {awburst, arburst}, {2'b01, 2'b01});
        checkOutput("const_misc", {awcache, awprot, awlock, awregion, awqos, awuser,
                    arcache, arprot, arlock, arregion, arqos, aruser, wuser}, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // single-beat write, OKAY
        applyStimulus(1'b1, 8'h10, 8'd0, 4'd3);
        addrPhase(1'b1, 0, 8'h10, 8'd0, 4'd3);
        wd_valid = 1; wd_data = 32'hDEADBEEF; wd_strb = 4'hF; wready = 1;
        #1;
        checkOutput("w1_awvalid_off", awvalid, 0);
        checkOutput("w1_wvalid", wvalid, 1);
        checkOutput("w1_wlast", wlast, 1);
        checkOutput("w1_wdata", wdata, 32'hDEADBEEF);
        checkOutput("w1_wstrb", wstrb, 4'hF);
        checkOutput("w1_wd_ready", wd_ready, 1);
        step();
        wd_valid = 0; wready = 0; bwvalid = 1; bresp = 2'd0;
        #1;
        checkOutput("w1_bwready", bwready, 1);
        checkOutput("w1_wr_done", wr_done, 1);
        checkOutput("w1_wr_resp", wr_resp, 0);
        step();
        bwvalid = 0;
        #1;
        checkOutput("w1_done_pulse", wr_done, 0);
        checkOutput("w1_back_idle", cmd_ready, 1);

        // 4-beat write, AW delayed 5 cycles, beat 2 stalled 2 cycles
        applyStimulus(1'b1, 8'h40, 8'd3, 4'd5);
        addrPhase(1'b1, 5, 8'h40, 8'd3, 4'd5);
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            wd_valid = 1; wd_data = 32'(i + 1); wd_strb = 4'hF;
            if (i == 1) begin
                wready = 0;
                for (int s = 0; s < 2; s++) begin
                    #1;
                    checkOutput("w4_stall_wvalid", wvalid, 1);
                    checkOutput("w4_stall_wdata", wdata, 2);
                    checkOutput("w4_stall_wd_ready", wd_ready, 0);
                    checkOutput("w4_stall_wlast", wlast, 0);
                    step();
                end
            end
            wready = 1;
            #1;
            checkOutput("w4_wdata", wdata, 32'(i + 1));
            checkOutput("w4_wlast", wlast, (i == 3));
            if (wvalid && wready) hs++;
            step();
        end
        #1;
        checkOutput("w4_no_extra_beat", wvalid, 0);
        checkOutput("w4_handshakes", hs, 4);
        wd_valid = 0; wready = 0; bwvalid = 1; bresp = 2'd0;
        #1;
        checkOutput("w4_wr_done", wr_done, 1);
        step();
        bwvalid = 0;

        // 8-beat read, AR delayed 5 cycles, one idle gap mid-burst
        applyStimulus(1'b0, 8'h20, 8'd7, 4'd1);
        addrPhase(1'b0, 5, 8'h20, 8'd7, 4'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                rvalid = 0;
                #1;
                checkOutput("r8_gap_rd_valid", rd_valid, 0);
                step();
            end
            rvalid = 1; rdata = 32'hA0 + 32'(i); rresp = 2'd0; rlast = (i == 7);
            #1;
            checkOutput("r8_rready", rready, 1);
            checkOutput("r8_rd_valid", rd_valid, 1);
            checkOutput("r8_rd_data", rd_data, 32'hA0 + 32'(i));
            checkOutput("r8_rd_last", rd_last, (i == 7));
            checkOutput("r8_rd_resp", rd_resp, 0);
            step();
        end
        rvalid = 0; rlast = 0;
        #1;
        checkOutput("r8_back_idle", cmd_ready, 1);
        checkOutput("r8_rready_off", rready, 0);

        // error responses are forwarded and transactions still complete
        applyStimulus(1'b1, 8'h50, 8'd0, 4'd2);
        addrPhase(1'b1, 1, 8'h50, 8'd0, 4'd2);
        wd_valid = 1; wd_data = 32'h12345678; wready = 1;
        step();
        wd_valid = 0; wready = 0; bwvalid = 1; bresp = 2'd2;
        #1;
        checkOutput("err_wr_done", wr_done, 1);
        checkOutput("err_wr_resp", wr_resp, 2);
        step();
        bwvalid = 0; bresp = 0;
        applyStimulus(1'b0, 8'h60, 8'd1, 4'd4);
        addrPhase(1'b0, 0, 8'h60, 8'd1, 4'd4);
        rvalid = 1; rdata = 32'h55; rresp = 2'd3; rlast = 0;
        #1;
        checkOutput("err_rd_resp", rd_resp, 3);
        step();
        rdata = 32'h66; rresp = 2'd0; rlast = 1;
        #1;
        checkOutput("err_rd_continue", {rd_valid, rd_last}, 2'b11);
        checkOutput("err_rd_data", rd_data, 32'h66);
        step();
        rvalid = 0; rlast = 0;
        #1;
        checkOutput("err_back_idle", cmd_ready, 1);

        // reset asserted during beat 2 of a 4-beat write
        applyStimulus(1'b1, 8'h70, 8'd3, 4'd6);
        addrPhase(1'b1, 0, 8'h70, 8'd3, 4'd6);
        wd_valid = 1; wd_data = 32'h1; wready = 1;
        step();
        wd_data = 32'h2;
        #1;
        checkOutput("rb_wvalid_pre", wvalid, 1);
        aresetn = 0;
        #1;
        checkOutput("rb_wvalid_drop", wvalid, 0);
        checkOutput("rb_awvalid_drop", awvalid, 0);
        checkOutput("rb_awlen_clear", awlen, 0);
        step();
        aresetn = 1; wd_valid = 0; wready = 0;
        #1;
        checkOutput("rb_idle_after", cmd_ready, 1);
        checkOutput("rb_no_wvalid", wvalid, 0);
        applyStimulus(1'b0, 8'h30, 8'd0, 4'd7);
        addrPhase(1'b0, 0, 8'h30, 8'd0, 4'd7);
        rvalid = 1; rdata = 32'hCAFE; rresp = 2'd0; rlast = 1;
        #1;
        checkOutput("rb_read_data", rd_data, 32'hCAFE);
        checkOutput("rb_read_last", {rd_valid, rd_last}, 2'b11);
        step();
        rvalid = 0; rlast = 0;
        #1;
        checkOutput("rb_read_done", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
